// File: rtl/iic_master_burst.sv
// rtl/iic_master_burst.sv - I2C write master: START, address+W, streamed data burst, STOP
module iic_master_burst #(
  parameter logic [6:0] SADDR   = 7'h27,
  parameter int         QTR_CNT = 125,
  parameter int         LEN_W   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic [7:0]       i_tx_data,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  input  logic             i_i2c_sda,
  output logic             o_i2c_scl,
  output logic             o_i2c_sda,
  output logic             o_i2c_busy,
  output logic             o_done,
  output logic             o_nack
);

  localparam int               QW      = (QTR_CNT > 1) ? $clog2(QTR_CNT) : 1;
  localparam logic [QW-1:0]    Q_LAST  = QW'(QTR_CNT - 1);
  localparam logic [QW-1:0]    Q_ONE   = QW'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_AACK,
    S_LOAD,
    S_DATA,
    S_DACK,
    S_STOP
  } state_t;

  state_t           state;
  logic [QW-1:0]    qcnt;      // cycle within the current quarter
  logic [1:0]       qtr;       // quarter within the current bit slot
  logic [2:0]       bit_cnt;   // bit index within the address/data byte
  logic [7:0]       shreg;     // shreg[7] is the bit currently on SDA
  logic [LEN_W-1:0] remain;    // data bytes still to be pulled from the stream
  logic             ack_nack;  // SDA level captured in the ACK slot
  logic             qend;

  assign qend       = (qcnt == Q_LAST);
  assign o_tx_ready = (state == S_LOAD);
  assign o_i2c_busy = (state != S_IDLE);

  // Bus sequencer: bit-slot timing, byte shifting, ACK evaluation and registered SCL/SDA drive
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      qcnt      <= '0;
      qtr       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      remain    <= '0;
      ack_nack  <= 1'b0;
      o_i2c_scl <= 1'b1;
      o_i2c_sda <= 1'b1;
      o_done    <= 1'b0;
      o_nack    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // The cycle that reports o_done is still IDLE but must not launch a new burst.
          if (i_start && !o_done) begin
            remain    <= i_len;
            o_nack    <= 1'b0;
            ack_nack  <= 1'b0;
            shreg     <= {SADDR, 1'b0};
            bit_cnt   <= '0;
            qcnt      <= '0;
            qtr       <= '0;
            o_i2c_scl <= 1'b1;
            o_i2c_sda <= 1'b1;
            state     <= S_START;
          end
        end

        S_LOAD: begin
          // SCL already low and the quarter counter parked at Q0; wait for the next byte.
          if (i_tx_valid) begin
            shreg     <= i_tx_data;
            remain    <= remain - LEN_ONE;
            bit_cnt   <= '0;
            o_i2c_sda <= i_tx_data[7];
            state     <= S_DATA;
          end
        end

        default: begin
          if (!qend) begin
            qcnt <= qcnt + Q_ONE;
          end else begin
            qcnt <= '0;
            qtr  <= qtr + 2'd1;

            // Q1 -> Q2: SCL rises; START drops SDA while SCL is high.
            if (qtr == 2'd1) begin
              o_i2c_scl <= 1'b1;
              if (state == S_START) begin
                o_i2c_sda <= 1'b0;
              end
            end

            // Q2 -> Q3: capture the slave's ACK; STOP releases SDA while SCL is high.
            if (qtr == 2'd2) begin
              if (state == S_AACK || state == S_DACK) begin
                ack_nack <= i_i2c_sda;
              end
              if (state == S_STOP) begin
                o_i2c_sda <= 1'b1;
              end
            end

            // Q3 -> Q0: end of bit slot, SCL falls and the next slot's SDA is presented.
            if (qtr == 2'd3) begin
              o_i2c_scl <= 1'b0;
              case (state)
                S_START: begin
                  o_i2c_sda <= shreg[7];
                  state     <= S_ADDR;
                end
                S_ADDR, S_DATA: begin
                  if (bit_cnt == 3'd7) begin
                    o_i2c_sda <= 1'b1;
                    state     <= (state == S_ADDR) ? S_AACK : S_DACK;
                  end else begin
                    bit_cnt   <= bit_cnt + 3'd1;
                    shreg     <= {shreg[6:0], 1'b0};
                    o_i2c_sda <= shreg[6];
                  end
                end
                S_AACK, S_DACK: begin
                  if (ack_nack) begin
                    o_nack    <= 1'b1;
                    o_i2c_sda <= 1'b0;
                    state     <= S_STOP;
                  end else if (remain == '0) begin
                    o_i2c_sda <= 1'b0;
                    state     <= S_STOP;
                  end else begin
                    state <= S_LOAD;
                  end
                end
                S_STOP: begin
                  o_i2c_scl <= 1'b1;
                  o_i2c_sda <= 1'b1;
                  o_done    <= 1'b1;
                  state     <= S_IDLE;
                end
                default: begin
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
